// File: rtl/channel_request_queue.sv
// Request FIFO in front of a single memory-controller channel, one request in flight at a time.
// Define CRQ_STATS_EN to build the timeout_cnt / done_cnt statistics registers.
module channel_request_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ADDR_WIDTH-1:0]   s_addr,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic                    s_wr_en,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [DATA_WIDTH-1:0]   r_rdata,
    output logic                    r_wr,
    output logic                    r_err,
    output logic                    ch_req,
    output logic [ADDR_WIDTH-1:0]   ch_addr,
    output logic [DATA_WIDTH-1:0]   ch_wdata,
    output logic                    ch_wr_en,
    input  logic                    ch_ack,
    input  logic [DATA_WIDTH-1:0]   ch_rdata,
    input  logic                    ch_valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             timeout_cnt,
    output logic [31:0]             done_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int WAIT_W  = $clog2(TIMEOUT + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;

    state_t                 state_reg, state_next;
    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]         count_reg;
    logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
    logic [ADDR_WIDTH-1:0]  cmd_addr_reg;
    logic [DATA_WIDTH-1:0]  cmd_wdata_reg;
    logic                   cmd_wr_en_reg;
    logic [DATA_WIDTH-1:0]  r_rdata_reg;
    logic                   r_wr_reg, r_err_reg;

    logic                   push, pop;
    logic                   capture, cap_wr, cap_err, resp_done;
    logic [DATA_WIDTH-1:0]  cap_data;
    logic [ENTRY_W-1:0]     head;

    assign s_ready  = (count_reg < DEPTH_CNT);
    assign push     = s_valid & s_ready;
    assign pop      = (state_reg == IDLE) && (count_reg != '0);
    assign head     = mem[rd_ptr_reg];

    assign count    = count_reg;
    assign ch_req   = (state_reg == ISSUE);
    assign ch_addr  = cmd_addr_reg;
    assign ch_wdata = cmd_wdata_reg;
    assign ch_wr_en = cmd_wr_en_reg;
    assign r_valid  = (state_reg == RESP);
    assign r_rdata  = r_rdata_reg;
    assign r_wr     = r_wr_reg;
    assign r_err    = r_err_reg;

    // Queue storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {s_addr, s_wdata, s_wr_en};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Completion (ack for writes, data for reads) wins over a timeout in the same cycle.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        capture       = 1'b0;
        cap_wr        = 1'b0;
        cap_err       = 1'b0;
        cap_data      = '0;
        resp_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next    = ISSUE;
                    wait_cnt_next = '0;
                end
            end
            ISSUE: begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
                if (ch_ack) begin
                    if (cmd_wr_en_reg) begin
                        state_next = RESP;
                        capture    = 1'b1;
                        cap_wr     = 1'b1;
                    end else if (ch_valid) begin
                        state_next = RESP;
                        capture    = 1'b1;
                        cap_data   = ch_rdata;
                    end else begin
                        state_next = WAIT_DATA;
                    end
                end else if (wait_cnt_reg >= WAIT_LAST) begin
                    state_next = RESP;
                    capture    = 1'b1;
                    cap_err    = 1'b1;
                end
            end
            WAIT_DATA: begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
                if (ch_valid) begin
                    state_next = RESP;
                    capture    = 1'b1;
                    cap_data   = ch_rdata;
                end else if (wait_cnt_reg >= WAIT_LAST) begin
                    state_next = RESP;
                    capture    = 1'b1;
                    cap_err    = 1'b1;
                end
            end
            RESP: begin
                if (r_ready) begin
                    state_next = IDLE;
                    resp_done  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            cmd_wr_en_reg <= 1'b0;
            r_rdata_reg   <= '0;
            r_wr_reg      <= 1'b0;
            r_err_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (pop) begin
                cmd_addr_reg  <= head[ENTRY_W-1 -: ADDR_WIDTH];
                cmd_wdata_reg <= head[DATA_WIDTH:1];
                cmd_wr_en_reg <= head[0];
            end
            if (capture) begin
                r_rdata_reg <= cap_data;
                r_wr_reg    <= cap_wr;
                r_err_reg   <= cap_err;
            end else if (resp_done) begin
                r_err_reg <= 1'b0;
            end
        end
    end

`ifdef CRQ_STATS_EN
    logic [15:0] timeout_cnt_reg;
    logic [31:0] done_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt_reg <= '0;
            done_cnt_reg    <= '0;
        end else begin
            if (cap_err && (timeout_cnt_reg != 16'hFFFF)) timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            if (resp_done) done_cnt_reg <= done_cnt_reg + 1'b1;
        end
    end

    assign timeout_cnt = timeout_cnt_reg;
    assign done_cnt    = done_cnt_reg;
`else
    assign timeout_cnt = '0;
    assign done_cnt    = '0;
`endif

endmodule
